// File: rtl/dl_scramble_pkg.sv
// Shared constants and helpers for the link scrambler/descrambler pair.
package dl_scramble_pkg;

    localparam int unsigned   DL_SCR_POLY7_DEG  = 7;
    localparam logic [6:0]    DL_SCR_POLY7      = 7'b110_0000;

    // x^58 + x^39 + 1: taps at delays 39 and 58
    localparam int unsigned   DL_SCR_POLY58_DEG = 58;
    localparam logic [57:0]   DL_SCR_POLY58     = (58'd1 << 57) | (58'd1 << 38);

    // Width of a counter that must hold values 0..state_bits
    function automatic int unsigned lock_cnt_w(input int unsigned state_bits);
        return $unsigned($clog2(state_bits + 1));
    endfunction

endpackage

// File: rtl/dl_descramble_step.sv
// One beat of self-synchronising descrambling: {hist, data} -> {out_bits, next_hist}.
module dl_descramble_step #(
    parameter int unsigned            NUM_BITS   = 8,
    parameter int unsigned            STATE_BITS = 7,
    parameter logic [STATE_BITS-1:0]  TAPS       = 7'b110_0000
) (
    input  logic [STATE_BITS-1:0] hist,
    input  logic [NUM_BITS-1:0]   in_data,
    output logic [NUM_BITS-1:0]   out_bits,
    output logic [STATE_BITS-1:0] next_hist
);

    localparam int unsigned EXT_W = STATE_BITS + NUM_BITS;

    // Time-ordered stream: ext[0] oldest history bit, ext[EXT_W-1] newest input bit
    logic [EXT_W-1:0] ext;

    always_comb begin
        ext       = '0;
        out_bits  = '0;
        next_hist = '0;
        for (int m = 0; m < STATE_BITS; m++) begin
            ext[STATE_BITS - 1 - m] = hist[m];
        end
        for (int i = 0; i < NUM_BITS; i++) begin
            ext[STATE_BITS + i] = in_data[i];
        end
        for (int i = 0; i < NUM_BITS; i++) begin
            out_bits[i] = ext[STATE_BITS + i];
            for (int k = 0; k < STATE_BITS; k++) begin
                if (TAPS[k]) begin
                    out_bits[i] = out_bits[i] ^ ext[STATE_BITS + i - k - 1];
                end
            end
        end
        for (int m = 0; m < STATE_BITS; m++) begin
            next_hist[m] = ext[EXT_W - 1 - m];
        end
    end

endmodule

// File: rtl/dl_descrambler.sv
// Receive-side descrambler with valid/ready handshake, one-beat output register and lock tracking.
module dl_descrambler
    import dl_scramble_pkg::*;
#(
    parameter int unsigned            NUM_BITS   = 8,
    parameter int unsigned            STATE_BITS = DL_SCR_POLY7_DEG,
    parameter logic [STATE_BITS-1:0]  TAPS       = DL_SCR_POLY7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_val,
    output logic                in_rdy,
    input  logic [NUM_BITS-1:0] in_data,
    output logic                out_val,
    input  logic                out_rdy,
    output logic [NUM_BITS-1:0] out_data,
    output logic                locked
);

    localparam int unsigned CNT_W = lock_cnt_w(STATE_BITS);

    logic [STATE_BITS-1:0] hist;
    logic [STATE_BITS-1:0] hist_nxt;
    logic [NUM_BITS-1:0]   step_bits;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  accept;

    dl_descramble_step #(
        .NUM_BITS   (NUM_BITS),
        .STATE_BITS (STATE_BITS),
        .TAPS       (TAPS)
    ) u_step (
        .hist      (hist),
        .in_data   (in_data),
        .out_bits  (step_bits),
        .next_hist (hist_nxt)
    );

    assign in_rdy = !flush && (!out_val || out_rdy);
    assign accept = in_val && in_rdy;

    // Saturating count of received bits
    always_comb begin
        cnt_nxt = CNT_W'(STATE_BITS);
        if (32'(bit_cnt) + NUM_BITS < STATE_BITS) begin
            cnt_nxt = bit_cnt + CNT_W'(NUM_BITS);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            hist     <= '0;
            bit_cnt  <= '0;
            locked   <= 1'b0;
            out_val  <= 1'b0;
            out_data <= '0;
        end else if (accept) begin
            hist     <= hist_nxt;
            bit_cnt  <= cnt_nxt;
            locked   <= (cnt_nxt == CNT_W'(STATE_BITS));
            out_val  <= 1'b1;
            out_data <= step_bits;
        end else if (out_val && out_rdy) begin
            out_val  <= 1'b0;
        end
    end

endmodule
